// File: rtl/mips_main_fsm.sv
// Multi-cycle main control FSM for the MIPS core (Moore, one state per cycle).
// Decodes IR opcode/funct and sequences every mips_datapath control strobe.
// Ports:
//   clk, rst (synchronous, active-high)
//   ir_opcode, ir_funct       : IR[31:26], IR[5:0]
//   alu_opcode                : operation code for ALU control
//   pc_write_cond, pc_write   : conditional / unconditional PC load
//   i_or_d, mem_read/write    : memory address select and strobes
//   mem_to_reg, ir_write      : write-data select, IR load
//   is_signed                 : immediate sign-extend select
//   pc_source, alu_src_a/b    : mux selects
//   reg_write, reg_dest       : register-file write enable, rd/rt select
//   jump_and_link             : write PC into r31
//   fsm_state                 : 4-bit debug view of the state register
// Optional feature: define MIPS_JAL_EN to build the JAL state (opcode 0x03).
module mips_main_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] ir_opcode,
    input  logic [5:0] ir_funct,
    output logic [5:0] alu_opcode,
    output logic       pc_write_cond,
    output logic       pc_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       ir_write,
    output logic       is_signed,
    output logic [1:0] pc_source,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       reg_write,
    output logic       reg_dest,
    output logic       jump_and_link,
    output logic [3:0] fsm_state
);

    localparam int unsigned STATE_W = 5;

    // More states than 4 bits can name; HALT and JAL live above 0xF and
    // alias onto the debug view (HALT reads as 0x0 like INIT, both drive
    // nothing; JAL reads as 0xF like JUMP, its close sibling).
    typedef enum logic [STATE_W-1:0] {
        S_INIT       = 5'h00,
        S_FETCH      = 5'h01,
        S_FETCH_WAIT = 5'h02,
        S_DECODE     = 5'h03,
        S_RTYPE_EXEC = 5'h04,
        S_RTYPE_WB   = 5'h05,
        S_ITYPE_EXEC = 5'h06,
        S_ITYPE_WB   = 5'h07,
        S_MEM_ADDR   = 5'h08,
        S_MEM_READ   = 5'h09,
        S_LOAD_WAIT  = 5'h0A,
        S_LOAD_WB    = 5'h0B,
        S_MEM_WRITE  = 5'h0C,
        S_BRANCH     = 5'h0D,
        S_JR         = 5'h0E,
        S_JUMP       = 5'h0F,
        S_HALT       = 5'h10
`ifdef MIPS_JAL_EN
        , S_JAL      = 5'h1F
`endif
    } state_t;

    typedef struct packed {
        logic [5:0] alu_opcode;
        logic       pc_write_cond;
        logic       pc_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       is_signed;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic       reg_dest;
    } ctrl_t;

    state_t state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;
`ifdef MIPS_JAL_EN
    logic   jal_q, jal_d;
`endif

    // Next state, then the control word of that next state so the outputs
    // are registered yet line up with the state they belong to.
    always_comb begin
        state_d = S_FETCH;
        ctrl_d  = '0;
`ifdef MIPS_JAL_EN
        jal_d   = 1'b0;
`endif
        case (state_q)
            S_INIT:       state_d = S_FETCH;
            S_FETCH:      state_d = S_FETCH_WAIT;
            S_FETCH_WAIT: state_d = S_DECODE;
            S_DECODE: begin
                case (ir_opcode)
                    6'h00:        state_d = (ir_funct == 6'h08) ? S_JR : S_RTYPE_EXEC;
                    6'h23, 6'h2B: state_d = S_MEM_ADDR;
                    6'h09, 6'h0A, 6'h0B,
                    6'h0C, 6'h0D, 6'h0E: state_d = S_ITYPE_EXEC;
                    6'h01, 6'h04, 6'h05,
                    6'h06, 6'h07: state_d = S_BRANCH;
                    6'h02:        state_d = S_JUMP;
`ifdef MIPS_JAL_EN
                    6'h03:        state_d = S_JAL;
`endif
                    6'h3F:        state_d = S_HALT;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_RTYPE_EXEC: state_d = S_RTYPE_WB;
            S_ITYPE_EXEC: state_d = S_ITYPE_WB;
            S_MEM_ADDR:   state_d = (ir_opcode == 6'h23) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:   state_d = S_LOAD_WAIT;
            S_LOAD_WAIT:  state_d = S_LOAD_WB;
            S_HALT:       state_d = S_HALT;
            default:      state_d = S_FETCH;
        endcase

        case (state_d)
            S_FETCH: begin
                ctrl_d.mem_read   = 1'b1;
                ctrl_d.alu_src_b  = 2'b01;
                ctrl_d.alu_opcode = 6'h21;
                ctrl_d.pc_write   = 1'b1;
            end
            S_FETCH_WAIT: ctrl_d.ir_write = 1'b1;
            S_DECODE: begin
                ctrl_d.alu_src_b  = 2'b11;
                ctrl_d.is_signed  = 1'b1;
                ctrl_d.alu_opcode = 6'h21;
            end
            S_RTYPE_EXEC: begin
                ctrl_d.alu_src_a  = 1'b1;
                ctrl_d.alu_opcode = ir_funct;
            end
            S_RTYPE_WB: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.reg_dest   = 1'b1;
                ctrl_d.alu_opcode = ir_funct;
            end
            S_ITYPE_EXEC, S_ITYPE_WB: begin
                ctrl_d.alu_src_a  = 1'b1;
                ctrl_d.alu_src_b  = 2'b10;
                ctrl_d.alu_opcode = ir_opcode;
                // logical immediates (andi/ori/xori) zero-extend
                ctrl_d.is_signed  = !(ir_opcode inside {6'h0C, 6'h0D, 6'h0E});
                ctrl_d.reg_write  = (state_d == S_ITYPE_WB);
            end
            S_MEM_ADDR: begin
                ctrl_d.alu_src_a  = 1'b1;
                ctrl_d.alu_src_b  = 2'b10;
                ctrl_d.is_signed  = 1'b1;
                ctrl_d.alu_opcode = 6'h21;
            end
            S_MEM_READ: begin
                ctrl_d.i_or_d   = 1'b1;
                ctrl_d.mem_read = 1'b1;
            end
            S_LOAD_WB: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl_d.i_or_d    = 1'b1;
                ctrl_d.mem_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl_d.alu_src_a     = 1'b1;
                ctrl_d.alu_opcode    = ir_opcode;
                ctrl_d.pc_source     = 2'b01;
                ctrl_d.pc_write_cond = 1'b1;
            end
            S_JR: begin
                ctrl_d.alu_src_a  = 1'b1;
                ctrl_d.alu_opcode = 6'h08;
                ctrl_d.pc_write   = 1'b1;
            end
            S_JUMP: begin
                ctrl_d.pc_source = 2'b10;
                ctrl_d.pc_write  = 1'b1;
            end
`ifdef MIPS_JAL_EN
            S_JAL: begin
                ctrl_d.pc_source = 2'b10;
                ctrl_d.pc_write  = 1'b1;
                ctrl_d.reg_write = 1'b1;
                jal_d            = 1'b1;
            end
`endif
            default: ctrl_d = '0;
        endcase
    end

    // State and control-word registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            ctrl_q  <= '0;
`ifdef MIPS_JAL_EN
            jal_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
`ifdef MIPS_JAL_EN
            jal_q   <= jal_d;
`endif
        end
    end

    assign alu_opcode    = ctrl_q.alu_opcode;
    assign pc_write_cond = ctrl_q.pc_write_cond;
    assign pc_write      = ctrl_q.pc_write;
    assign i_or_d        = ctrl_q.i_or_d;
    assign mem_read      = ctrl_q.mem_read;
    assign mem_write     = ctrl_q.mem_write;
    assign mem_to_reg    = ctrl_q.mem_to_reg;
    assign ir_write      = ctrl_q.ir_write;
    assign is_signed     = ctrl_q.is_signed;
    assign pc_source     = ctrl_q.pc_source;
    assign alu_src_a     = ctrl_q.alu_src_a;
    assign alu_src_b     = ctrl_q.alu_src_b;
    assign reg_write     = ctrl_q.reg_write;
    assign reg_dest      = ctrl_q.reg_dest;
    assign fsm_state     = state_q[3:0];
`ifdef MIPS_JAL_EN
    assign jump_and_link = jal_q;
`else
    assign jump_and_link = 1'b0;
`endif

endmodule

// File: tb/tb_mips_main_fsm.sv
// Self-checking bench for mips_main_fsm: directed per-state vectors, reset /
// halt corner sequences, and random instruction streams checked against an
// instruction-level model (CPI and per-instruction strobe counts).
module tb_mips_main_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] ir_opcode, ir_funct;
    logic [5:0] alu_opcode;
    logic       pc_write_cond, pc_write, i_or_d, mem_read, mem_write;
    logic       mem_to_reg, ir_write, is_signed, alu_src_a;
    logic [1:0] pc_source, alu_src_b;
    logic       reg_write, reg_dest, jump_and_link;
    logic [3:0] fsm_state;

    int total = 0;
    int bad   = 0;

    mips_main_fsm dut (
        .clk(clk), .rst(rst), .ir_opcode(ir_opcode), .ir_funct(ir_funct),
        .alu_opcode(alu_opcode), .pc_write_cond(pc_write_cond), .pc_write(pc_write),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .ir_write(ir_write), .is_signed(is_signed),
        .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .reg_write(reg_write), .reg_dest(reg_dest), .jump_and_link(jump_and_link),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    // strb = {pc_write_cond, pc_write, i_or_d, mem_read, mem_write, mem_to_reg, ir_write, is_signed}
    // wr   = {reg_write, reg_dest, jump_and_link}
    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        int         step;
        logic [3:0] st;
        logic [5:0] alu;
        logic [7:0] strb;
        logic [1:0] psrc;
        logic       asa;
        logic [1:0] asb;
        logic [2:0] wr;
    } vec_t;

    localparam int N_VEC = 22;
    vec_t vecs [N_VEC];

    localparam logic [25:0] FETCH_OBS = {4'h1, 6'h21, 8'b0101_0000, 2'b00, 1'b0, 2'b01, 3'b000};

    function automatic logic [25:0] obs();
        return {fsm_state, alu_opcode,
                pc_write_cond, pc_write, i_or_d, mem_read, mem_write, mem_to_reg, ir_write, is_signed,
                pc_source, alu_src_a, alu_src_b, reg_write, reg_dest, jump_and_link};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // leaves the bench at the negedge of the first FETCH cycle
    task automatic reset_to_fetch();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Instruction-level model: cycles per instruction and strobe counts,
    // packed {pc_write, reg_write, mem_read, mem_write, pc_write_cond, ir_write, jal}.
    task automatic model(input logic [5:0] op, input logic [5:0] funct,
                         output int cpi, output logic [27:0] cnt,
                         output logic has_wb, output logic [5:0] wb_alu);
        int pcw = 1, rw = 0, mr = 1, mw = 0, pwc = 0, jal = 0;
        cpi = 3; has_wb = 1'b0; wb_alu = 6'h00;
        if (op == 6'h00 && funct == 6'h08) begin cpi = 4; pcw = 2; end
        else if (op == 6'h00) begin cpi = 5; rw = 1; has_wb = 1'b1; wb_alu = funct; end
        else if (op == 6'h23) begin cpi = 7; mr = 2; rw = 1; has_wb = 1'b1; end
        else if (op == 6'h2B) begin cpi = 5; mw = 1; end
        else if (op >= 6'h09 && op <= 6'h0E) begin cpi = 5; rw = 1; has_wb = 1'b1; wb_alu = op; end
        else if (op == 6'h01 || (op >= 6'h04 && op <= 6'h07)) begin cpi = 4; pwc = 1; end
        else if (op == 6'h02) begin cpi = 4; pcw = 2; end
`ifdef MIPS_JAL_EN
        else if (op == 6'h03) begin cpi = 4; pcw = 2; rw = 1; jal = 1; has_wb = 1'b1; end
`endif
        cnt = {4'(pcw), 4'(rw), 4'(mr), 4'(mw), 4'(pwc), 4'd1, 4'(jal)};
    endtask

    initial begin
        logic [5:0] ops [17];
        rst = 1'b1; ir_opcode = 6'h00; ir_funct = 6'h00;

        vecs[0]  = '{6'h00, 6'h21, 0, 4'h1, 6'h21, 8'b0101_0000, 2'b00, 1'b0, 2'b01, 3'b000};
        vecs[1]  = '{6'h00, 6'h21, 1, 4'h2, 6'h00, 8'b0000_0010, 2'b00, 1'b0, 2'b00, 3'b000};
        vecs[2]  = '{6'h00, 6'h21, 2, 4'h3, 6'h21, 8'b0000_0001, 2'b00, 1'b0, 2'b11, 3'b000};
        vecs[3]  = '{6'h00, 6'h21, 3, 4'h4, 6'h21, 8'b0000_0000, 2'b00, 1'b1, 2'b00, 3'b000};
        vecs[4]  = '{6'h00, 6'h21, 4, 4'h5, 6'h21, 8'b0000_0000, 2'b00, 1'b0, 2'b00, 3'b110};
        vecs[5]  = '{6'h00, 6'h21, 5, 4'h1, 6'h21, 8'b0101_0000, 2'b00, 1'b0, 2'b01, 3'b000};
        vecs[6]  = '{6'h23, 6'h00, 3, 4'h8, 6'h21, 8'b0000_0001, 2'b00, 1'b1, 2'b10, 3'b000};
        vecs[7]  = '{6'h23, 6'h00, 4, 4'h9, 6'h00, 8'b0011_0000, 2'b00, 1'b0, 2'b00, 3'b000};
        vecs[8]  = '{6'h23, 6'h00, 5, 4'hA, 6'h00, 8'b0000_0000, 2'b00, 1'b0, 2'b00, 3'b000};
        vecs[9]  = '{6'h23, 6'h00, 6, 4'hB, 6'h00, 8'b0000_0100, 2'b00, 1'b0, 2'b00, 3'b100};
        vecs[10] = '{6'h23, 6'h00, 7, 4'h1, 6'h21, 8'b0101_0000, 2'b00, 1'b0, 2'b01, 3'b000};
        vecs[11] = '{6'h2B, 6'h00, 4, 4'hC, 6'h00, 8'b0010_1000, 2'b00, 1'b0, 2'b00, 3'b000};
        vecs[12] = '{6'h0D, 6'h00, 3, 4'h6, 6'h0D, 8'b0000_0000, 2'b00, 1'b1, 2'b10, 3'b000};
        vecs[13] = '{6'h09, 6'h00, 3, 4'h6, 6'h09, 8'b0000_0001, 2'b00, 1'b1, 2'b10, 3'b000};
        vecs[14] = '{6'h09, 6'h00, 4, 4'h7, 6'h09, 8'b0000_0001, 2'b00, 1'b1, 2'b10, 3'b100};
        vecs[15] = '{6'h04, 6'h00, 3, 4'hD, 6'h04, 8'b1000_0000, 2'b01, 1'b1, 2'b00, 3'b000};
        vecs[16] = '{6'h00, 6'h08, 3, 4'hE, 6'h08, 8'b0100_0000, 2'b00, 1'b1, 2'b00, 3'b000};
        vecs[17] = '{6'h02, 6'h00, 3, 4'hF, 6'h00, 8'b0100_0000, 2'b10, 1'b0, 2'b00, 3'b000};
`ifdef MIPS_JAL_EN
        vecs[18] = '{6'h03, 6'h00, 3, 4'hF, 6'h00, 8'b0100_0000, 2'b10, 1'b0, 2'b00, 3'b101};
`else
        vecs[18] = '{6'h03, 6'h00, 3, 4'h1, 6'h21, 8'b0101_0000, 2'b00, 1'b0, 2'b01, 3'b000};
`endif
        vecs[19] = '{6'h3F, 6'h00, 3, 4'h0, 6'h00, 8'b0000_0000, 2'b00, 1'b0, 2'b00, 3'b000};
        vecs[20] = '{6'h10, 6'h00, 3, 4'h1, 6'h21, 8'b0101_0000, 2'b00, 1'b0, 2'b01, 3'b000};
        vecs[21] = '{6'h0E, 6'h00, 3, 4'h6, 6'h0E, 8'b0000_0000, 2'b00, 1'b1, 2'b10, 3'b000};

        // reset held three cycles, then released
        repeat (3) @(negedge clk);
        check("reset_init", 32'(obs()), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("first_fetch", 32'(obs()), 32'(FETCH_OBS));

        // directed per-state vectors
        for (int i = 0; i < N_VEC; i++) begin
            reset_to_fetch();
            ir_opcode = vecs[i].op;
            ir_funct  = vecs[i].funct;
            repeat (vecs[i].step) @(negedge clk);
            check($sformatf("vec%0d_op%0h_s%0d", i, vecs[i].op, vecs[i].step), 32'(obs()),
                  32'({vecs[i].st, vecs[i].alu, vecs[i].strb, vecs[i].psrc,
                       vecs[i].asa, vecs[i].asb, vecs[i].wr}));
        end

        // HALT stays put with no strobes until reset
        reset_to_fetch();
        ir_opcode = 6'h3F; ir_funct = 6'h00;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            ir_opcode = 6'($urandom);
            @(negedge clk);
            check($sformatf("halt_hold%0d", k), 32'(obs()), 32'h0);
        end
        rst = 1'b1;
        @(negedge clk);
        check("halt_rst_init", 32'(obs()), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("halt_rst_fetch", 32'(obs()), 32'(FETCH_OBS));

        // reset in the middle of a load (MEM_READ) leaves no partial strobe
        ir_opcode = 6'h23;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midinst_rst", 32'(obs()), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("midinst_fetch", 32'(obs()), 32'(FETCH_OBS));

        // random instruction stream against the instruction-level model
        ops = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                6'h0E, 6'h01, 6'h04, 6'h05, 6'h06, 6'h07, 6'h02, 6'h03};
        reset_to_fetch();
        for (int n = 0; n < 300; n++) begin
            int         cyc, exp_cpi;
            int         pcw, rw, mr, mw, pwc, irw, jal;
            logic [27:0] exp_cnt;
            logic        has_wb, done;
            logic [5:0]  exp_wb, wb_alu;
            logic [5:0]  op, fn;
            op = ($urandom_range(0, 5) == 0) ? 6'($urandom) : ops[$urandom_range(0, 16)];
            if (op == 6'h3F) op = 6'h3E;
            fn = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom);
            ir_opcode = op; ir_funct = fn;
            model(op, fn, exp_cpi, exp_cnt, has_wb, exp_wb);
            cyc = 1; pcw = int'(pc_write); rw = 0; mr = int'(mem_read); mw = 0;
            pwc = 0; irw = 0; jal = 0; wb_alu = 6'h3F; done = 1'b0;
            for (int k = 0; k < 20 && !done; k++) begin
                @(negedge clk);
                if (fsm_state == 4'h1) done = 1'b1;
                else begin
                    cyc++;
                    pcw += int'(pc_write);   rw  += int'(reg_write);
                    mr  += int'(mem_read);   mw  += int'(mem_write);
                    pwc += int'(pc_write_cond); irw += int'(ir_write);
                    jal += int'(jump_and_link);
                    if (reg_write) wb_alu = alu_opcode;
                end
            end
            if (!done) begin
                check($sformatf("rnd%0d_timeout_op%0h", n, op), 32'd0, 32'd1);
                reset_to_fetch();
            end else begin
                check($sformatf("rnd%0d_cpi_op%0h_fn%0h", n, op, fn), 32'(cyc), 32'(exp_cpi));
                check($sformatf("rnd%0d_counts_op%0h_fn%0h", n, op, fn),
                      32'({4'(pcw), 4'(rw), 4'(mr), 4'(mw), 4'(pwc), 4'(irw), 4'(jal)}),
                      32'(exp_cnt));
                if (has_wb)
                    check($sformatf("rnd%0d_wb_alu_op%0h", n, op), 32'(wb_alu), 32'(exp_wb));
                check($sformatf("rnd%0d_fetch", n), 32'(obs()), 32'(FETCH_OBS));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
